// File: rtl/dpram_sclk_pipe.sv
// Single-clock simple dual-port RAM with byte-lane writes, 1/2-cycle read latency,
// read-valid strobe and an optional post-reset clear sweep.
module dpram_sclk_pipe #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BYTE_WIDTH    = 8,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned ENABLE_BYPASS = 1,
    parameter int unsigned INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic [NB-1:0]         wbe,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rvalid,
    output logic                  init_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("dpram_sclk_pipe: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("dpram_sclk_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? CLEAR : READY;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    clr_en;
    logic                    wr_en;
    logic                    rd_en;
    logic                    collide;
    logic [DATA_WIDTH-1:0]   wmask;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_data;

    for (genvar g = 0; g < NB; g++) begin : g_lane_mask
        assign wmask[g*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wbe[g]}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        init_busy = 1'b0;
        clr_en    = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        unique case (state)
            CLEAR: begin
                init_busy = 1'b1;
                clr_en    = rst_n;
                if (ptr == '1) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                wr_en = we & rst_n;
                rd_en = re & rst_n;
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Memory array is deliberately not reset; only the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[ptr] <= INIT_VALUE;
        end else if (wr_en) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (din & wmask);
        end
    end

    assign collide = (ENABLE_BYPASS != 0) && wr_en && (raddr == waddr);

    always_comb begin
        rd_word = mem[raddr];
        if (collide) begin
            rd_word = (mem[raddr] & ~wmask) | (din & wmask);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_data <= rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
                rvalid   <= 1'b0;
                dout     <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
                rvalid <= s2_valid;
                if (s2_valid) begin
                    dout <= s2_data;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rvalid <= 1'b0;
                dout   <= '0;
            end else begin
                rvalid <= s1_valid;
                if (s1_valid) begin
                    dout <= s1_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dpram_sclk_pipe.sv
// Directed bench: instance 0 = latency 1, bypass, clear sweep; instance 1 = latency 2, no bypass, no clear.
module tb_dpram_sclk_pipe;

    logic        clk;
    logic        rst_n  [2];
    logic        re     [2];
    logic        we     [2];
    logic [3:0]  raddr  [2];
    logic [3:0]  waddr  [2];
    logic [3:0]  wbe    [2];
    logic [31:0] din    [2];
    logic [31:0] dout   [2];
    logic        rvalid [2];
    logic        busy   [2];

    int total = 0;
    int bad   = 0;
    int rl_of [2] = '{1, 2};

    dpram_sclk_pipe #(
        .ADDR_WIDTH   (4),
        .DATA_WIDTH   (32),
        .BYTE_WIDTH   (8),
        .READ_LATENCY (1),
        .ENABLE_BYPASS(1),
        .INIT_ON_RESET(1),
        .INIT_VALUE   (32'hA5A5A5A5)
    ) u_a (
        .clk(clk), .rst_n(rst_n[0]), .raddr(raddr[0]), .re(re[0]),
        .waddr(waddr[0]), .we(we[0]), .wbe(wbe[0]), .din(din[0]),
        .dout(dout[0]), .rvalid(rvalid[0]), .init_busy(busy[0])
    );

    dpram_sclk_pipe #(
        .ADDR_WIDTH   (4),
        .DATA_WIDTH   (32),
        .BYTE_WIDTH   (8),
        .READ_LATENCY (2),
        .ENABLE_BYPASS(0),
        .INIT_ON_RESET(0),
        .INIT_VALUE   (32'h0)
    ) u_b (
        .clk(clk), .rst_n(rst_n[1]), .raddr(raddr[1]), .re(re[1]),
        .waddr(waddr[1]), .we(we[1]), .wbe(wbe[1]), .din(din[1]),
        .dout(dout[1]), .rvalid(rvalid[1]), .init_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        we[k] = 1'b1; waddr[k] = a; din[k] = d; wbe[k] = be;
        tick();
        we[k] = 1'b0;
    endtask

    // Waits (bounded) for rvalid after a read was accepted, then checks latency and data.
    task automatic await_rd(input int k, input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            if (rvalid[k]) break;
        end
        chk({tag, "_lat"}, n, rl_of[k]);
        chk({tag, "_data"}, dout[k], exp);
    endtask

    task automatic rd(input int k, input logic [3:0] a, input string tag, input logic [31:0] exp);
        re[k] = 1'b1; raddr[k] = a;
        tick();
        re[k] = 1'b0;
        await_rd(k, tag, exp);
    endtask

    task automatic collide(input int k, input logic [3:0] a, input string tag, input logic [31:0] exp);
        we[k] = 1'b1; waddr[k] = a; din[k] = 32'hFFFFFFFF; wbe[k] = 4'b0011;
        re[k] = 1'b1; raddr[k] = a;
        tick();
        we[k] = 1'b0; re[k] = 1'b0;
        await_rd(k, tag, exp);
    endtask

    // Counts cycles with init_busy high after release; holds re high and pulses a
    // write mid-sweep (both must be ignored). Optionally re-asserts reset at cnt==abort_at.
    task automatic count_busy(input int k, input int abort_at, output int cnt, output logic rv);
        cnt = 0; rv = 1'b0;
        re[k] = 1'b1; raddr[k] = 4'd0;
        waddr[k] = 4'd2; din[k] = 32'hDEADBEEF; wbe[k] = 4'hF;
        for (int n = 0; n < 64; n++) begin
            tick();
            cnt++;
            if (rvalid[k]) rv = 1'b1;
            we[k] = (cnt == 8);
            if (!busy[k]) break;
            if (cnt == abort_at) begin
                re[k] = 1'b0; we[k] = 1'b0; rst_n[k] = 1'b0;
                tick();
                rst_n[k] = 1'b1;
                break;
            end
        end
        re[k] = 1'b0; we[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        logic rv;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; re[k] = 1'b0; we[k] = 1'b0;
            raddr[k] = '0; waddr[k] = '0; wbe[k] = '0; din[k] = '0;
        end

        // Reset state and clear sweep on instance 0
        repeat (3) tick();
        chk("a_rst_busy", busy[0], 1);
        chk("a_rst_dout", dout[0], 0);
        chk("a_rst_rvalid", rvalid[0], 0);
        chk("b_rst_busy", busy[1], 0);
        chk("b_rst_rvalid", rvalid[1], 0);
        rst_n[0] = 1'b1;
        count_busy(0, 0, cnt, rv);
        chk("a_clr_cycles", cnt, 16);
        chk("a_clr_no_rvalid", rv, 0);
        for (int a = 0; a < 16; a++) begin
            rd(0, 4'(a), "a_clr_rd", 32'hA5A5A5A5);
        end

        // Byte enables
        wr(0, 4'd5, 32'h11223344, 4'hF);
        wr(0, 4'd5, 32'hAABBCCDD, 4'b0101);
        rd(0, 4'd5, "a_be", 32'h11BB33DD);

        // Collision with bypass
        wr(0, 4'd7, 32'h0, 4'hF);
        collide(0, 4'd7, "a_byp", 32'h0000FFFF);
        rd(0, 4'd7, "a_byp_after", 32'h0000FFFF);

        // Reset one cycle after a read, then abort the clear at ptr 9
        re[0] = 1'b1; raddr[0] = 4'd5;
        tick();
        re[0] = 1'b0; rst_n[0] = 1'b0;
        tick();
        chk("a_midrd_rv0", rvalid[0], 0);
        tick();
        chk("a_midrd_rv1", rvalid[0], 0);
        rst_n[0] = 1'b1;
        count_busy(0, 9, cnt, rv);
        chk("a_abort_busy", busy[0], 1);
        count_busy(0, 0, cnt, rv);
        chk("a_restart_cycles", cnt, 16);
        rd(0, 4'd5, "a_restart_rd", 32'hA5A5A5A5);
        rd(0, 4'd2, "a_restart_rd2", 32'hA5A5A5A5);

        // Instance 1: no clear, read issued in the first cycle after release
        rst_n[1] = 1'b1; re[1] = 1'b1; raddr[1] = 4'd0;
        tick();
        re[1] = 1'b0;
        chk("b_busy_rel", busy[1], 0);
        chk("b_first_rv_t1", rvalid[1], 0);
        tick();
        chk("b_first_rv_t2", rvalid[1], 0);
        tick();
        chk("b_first_rv_t3", rvalid[1], 1);
        tick();
        chk("b_first_rv_pulse", rvalid[1], 0);

        // Latency-2 back-to-back stream
        wr(1, 4'd1, 32'd1, 4'hF);
        wr(1, 4'd2, 32'd2, 4'hF);
        wr(1, 4'd3, 32'd3, 4'hF);
        re[1] = 1'b1; raddr[1] = 4'd1;
        tick();
        raddr[1] = 4'd2;
        chk("b_str_rv_t", rvalid[1], 0);
        tick();
        raddr[1] = 4'd3;
        chk("b_str_rv_t1", rvalid[1], 0);
        tick();
        re[1] = 1'b0;
        chk("b_str_rv_t2", rvalid[1], 1);
        chk("b_str_d_t2", dout[1], 32'd1);
        tick();
        chk("b_str_rv_t3", rvalid[1], 1);
        chk("b_str_d_t3", dout[1], 32'd2);
        tick();
        chk("b_str_rv_t4", rvalid[1], 1);
        chk("b_str_d_t4", dout[1], 32'd3);
        tick();
        chk("b_str_rv_t5", rvalid[1], 0);
        chk("b_str_hold", dout[1], 32'd3);

        // Collision without bypass
        wr(1, 4'd7, 32'h0, 4'hF);
        collide(1, 4'd7, "b_nobyp", 32'h00000000);
        rd(1, 4'd7, "b_nobyp_after", 32'h0000FFFF);

        // A write one edge after a latency-2 read must not leak into it
        re[1] = 1'b1; raddr[1] = 4'd7;
        tick();
        re[1] = 1'b0;
        we[1] = 1'b1; waddr[1] = 4'd7; din[1] = 32'h12345678; wbe[1] = 4'hF;
        tick();
        we[1] = 1'b0;
        tick();
        chk("b_late_wr_rv", rvalid[1], 1);
        chk("b_late_wr_d", dout[1], 32'h0000FFFF);
        rd(1, 4'd7, "b_late_wr_after", 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpram_sclk_pipe.md
Name: dpram_sclk_pipe

Overview:
Single-clock simple dual-port RAM with one write port and one read port. It adds four things to our basic dual-port RAM: byte-lane write enables, a selectable read latency of 1 or 2, a read-valid strobe, and an optional post-reset clear sequencer that initialises every location. Read-during-write forwarding is byte-accurate. Packet-router buffers use it where stale contents after reset are not acceptable.

Parameters:
ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, width of one byte lane; NB = DATA_WIDTH/BYTE_WIDTH
READ_LATENCY, 1, 1 = registered memory read; 2 = additional output register
ENABLE_BYPASS, 1, 1 = same-cycle read/write collision returns the new data; 0 = returns the old data
INIT_ON_RESET, 1, 1 = clear sequencer writes INIT_VALUE to all locations after reset
INIT_VALUE, 0, DATA_WIDTH-bit value written by the clear sequencer

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  synchronous, active-low reset
raddr  input  ADDR_WIDTH  read address
re  input  1  read enable
waddr  input  ADDR_WIDTH  write address
we  input  1  write enable
wbe  input  NB  byte-lane write enables; bit i covers din[i*BYTE_WIDTH +: BYTE_WIDTH]
din  input  DATA_WIDTH  write data
dout  output  DATA_WIDTH  read data
rvalid  output  1  one-cycle strobe, high when dout carries new read data
init_busy  output  1  clear sequencer active; we and re are ignored while high

Behaviour:
- Reset: rst_n is sampled at the rising edge of clk. While rst_n is low: dout=0, rvalid=0, all read pipeline stages are invalidated, and the clear pointer is set to 0.
  - init_busy = 1 during reset if INIT_ON_RESET=1, else 0.
  - Memory contents are not altered by reset itself.
- FSM has two states, CLEAR and READY.
  - Reset leads to CLEAR if INIT_ON_RESET=1, otherwise to READY.
- CLEAR state:
  - Starting with the first edge at which rst_n is high, each edge writes INIT_VALUE (all lanes) to mem[ptr] and increments ptr.
  - The edge that writes ptr = depth-1 moves the FSM to READY. init_busy deasserts in the same cycle the FSM enters READY.
  - Total: exactly 2**ADDR_WIDTH cycles with init_busy=1 after reset release.
  - In CLEAR, user we/re are ignored: no memory write, no rvalid.
- Reset asserted mid-CLEAR or mid-read:
  - In-flight reads are dropped (rvalid stays 0).
  - The clear restarts from ptr=0 after release.
- Write (READY state): at the edge with we=1, lane i of mem[waddr] takes the din lane for every i with wbe[i]=1. Other lanes keep their old value. we=1 with wbe=0 changes nothing.
- Read (READY state):
  - re=1 at edge t samples mem[raddr].
  - dout presents the data, and rvalid=1, after edge t+READ_LATENCY-1+1, i.e. 1 cycle later for READ_LATENCY=1 and 2 cycles later for READ_LATENCY=2.
  - rvalid is high for exactly one cycle per accepted read.
  - Back-to-back reads give a full-throughput stream.
  - dout holds its last value when rvalid=0.
- Collision: re=1 and we=1 at the same edge with raddr==waddr.
  - ENABLE_BYPASS=1: the returned word takes lanes with wbe[i]=1 from din and all other lanes from the old mem contents.
  - ENABLE_BYPASS=0: the returned word is the old mem contents.
- Only same-edge collisions are forwarded. A write at edge t+1 does not alter a READ_LATENCY=2 read sampled at edge t.
- Address wrap: addresses are modulo depth and there is no out-of-range case. The clear pointer does not wrap back into CLEAR.
- Parameter checks (elaboration time):
  - READ_LATENCY must be 1 or 2; any other value is an error.
  - DATA_WIDTH must be a multiple of BYTE_WIDTH; otherwise an error.

Test Plan:
1. Clear sweep: ADDR_WIDTH=4, INIT_ON_RESET=1, INIT_VALUE=32'hA5A5A5A5. Hold rst_n low for 3 cycles, then release.
   -> init_busy is high for exactly 16 cycles.
   -> A write with we=1 during the clear is dropped.
   -> Reading all 16 addresses afterwards returns A5A5A5A5 each time.
2. Byte enables: write 32'h11223344 to addr 5 with wbe=4'hF, then write 32'hAABBCCDD to addr 5 with wbe=4'b0101, then read addr 5.
   -> dout=32'h11BB33DD with rvalid=1.
3. Latency: READ_LATENCY=2. Issue re at edges t, t+1, t+2 to addresses 1, 2, 3, each preloaded with its own address value.
   -> rvalid is high at cycles t+2..t+4.
   -> dout=1, 2, 3 in order.
4. Collision: mem[7]=32'h00000000. Same edge: we=1, wbe=4'b0011, din=32'hFFFFFFFF, re=1, raddr=waddr=7.
   -> ENABLE_BYPASS=1: dout=32'h0000FFFF.
   -> ENABLE_BYPASS=0: dout=32'h00000000.
   -> In both cases a later read of address 7 returns 32'h0000FFFF.
5. Reset mid-read and mid-clear:
   -> Assert rst_n low one cycle after re: no rvalid pulse appears.
   -> Assert reset at clear ptr=9: after release, init_busy stays high for 16 full cycles.
6. INIT_ON_RESET=0: after reset release, init_busy=0 immediately, and a read issued in the first cycle produces rvalid after READ_LATENCY cycles.
